led_div_bank: RTL and testbench

- Parametrised multi-channel clock divider / LED blinker; successor to the single fixed 1 Hz divider.
- Each channel independently runs OFF, SQUARE, PWM or ON mode, with a half-period and duty programmable at run time over a valid/ready config port.
- Provides a per-channel one-cycle tick for downstream timing and a global sync for phase alignment.
- Sits between the 50 MHz board clock and the LED pins / slow-rate consumers.

---
 rtl/led_div_pkg.sv | 18 +
 rtl/led_div_chan.sv | 98 +++++++++
 rtl/led_div_bank.sv | 80 ++++++++
 tb/tb_led_div_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_div_pkg.sv
// Shared types and helpers for the multi-channel LED divider bank.
package led_div_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_ON     = 2'b11
  } mode_t;

  localparam int DEF_CNT_W = 26;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_div_chan.sv
// One divider channel: period counter, square phase, mode/half/duty registers.
// Outputs lit and tick are registered from next-state values.
module led_div_chan
  import led_div_pkg::*;
#(
  parameter int          CNT_W    = DEF_CNT_W,
  parameter int unsigned DEF_HALF = 25000000
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             load,
  input  mode_t            mode,
  input  logic [CNT_W-1:0] half,
  input  logic [CNT_W-1:0] duty,
  input  logic             sync,
  output logic             lit,
  output logic             tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);

  mode_t            mode_reg, mode_next;
  logic [CNT_W-1:0] half_reg, half_next;
  logic [CNT_W-1:0] duty_reg, duty_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;
  logic             lit_reg, lit_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] last_cnt;

  // A half-period of zero behaves as one clock.
  assign last_cnt = (half_reg == '0) ? '0 : half_reg - CNT_W'(1);

  always_comb begin
    mode_next  = mode_reg;
    half_next  = half_reg;
    duty_next  = duty_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    tick_next  = 1'b0;
    lit_next   = 1'b0;

    if (load) begin
      mode_next = mode;
      half_next = half;
      duty_next = duty;
    end

    // Load and sync both restart the period and override a coincident wrap.
    if (load || sync) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (mode_reg == MODE_SQUARE || mode_reg == MODE_PWM) begin
      if (cnt_reg == last_cnt) begin
        cnt_next  = '0;
        tick_next = 1'b1;
        if (mode_reg == MODE_SQUARE) begin
          phase_next = ~phase_reg;
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else begin
      cnt_next = '0;
    end

    case (mode_next)
      MODE_SQUARE: lit_next = phase_next;
      MODE_PWM:    lit_next = (cnt_next < duty_next);
      MODE_ON:     lit_next = 1'b1;
      default:     lit_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= MODE_SQUARE;
      half_reg  <= HALF_RST;
      duty_reg  <= '0;
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
      lit_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      mode_reg  <= mode_next;
      half_reg  <= half_next;
      duty_reg  <= duty_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      lit_reg   <= lit_next;
      tick_reg  <= tick_next;
    end
  end

  assign lit  = lit_reg;
  assign tick = tick_reg;

endmodule

// File: rtl/led_div_bank.sv
// Bank of CH independent LED dividers with a shared valid/ready config port,
// global sync, out-of-range channel error pulse and LED polarity selection.
module led_div_bank
  import led_div_pkg::*;
#(
  parameter int          CH             = 4,
  parameter int          CNT_W          = DEF_CNT_W,
  parameter int unsigned DEF_HALF       = 25000000,
  parameter bit          LED_ACTIVE_LOW = 1'b1,
  parameter int          CH_W           = sel_width(CH)
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             cfg_err,
  output logic [CH-1:0]    led_out,
  output logic [CH-1:0]    tick
);

  logic          cfg_ready_reg, cfg_ready_next;
  logic          cfg_err_reg, cfg_err_next;
  logic          xfer;
  logic          ch_bad;
  logic [CH-1:0] load;
  logic [CH-1:0] lit;
  mode_t         cfg_mode_e;

  assign xfer       = cfg_valid && cfg_ready_reg;
  assign ch_bad     = (32'(cfg_ch) >= 32'(CH));
  assign cfg_mode_e = mode_t'(cfg_mode);

  // Ready drops for the single cycle after each accepted transfer.
  always_comb begin
    cfg_ready_next = ~xfer;
    cfg_err_next   = xfer && ch_bad;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_ready_reg <= cfg_ready_next;
      cfg_err_reg   <= cfg_err_next;
    end
  end

  assign cfg_ready = cfg_ready_reg;
  assign cfg_err   = cfg_err_reg;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign load[gi] = xfer && (cfg_ch == CH_W'(gi));

      led_div_chan #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
      ) u_chan (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .load    (load[gi]),
        .mode    (cfg_mode_e),
        .half    (cfg_half),
        .duty    (cfg_duty),
        .sync    (sync),
        .lit     (lit[gi]),
        .tick    (tick[gi])
      );

      assign led_out[gi] = LED_ACTIVE_LOW ? ~lit[gi] : lit[gi];
    end
  endgenerate

endmodule

// File: tb/tb_led_div_bank.sv
// Directed bench for led_div_bank with CH=4, CNT_W=8, DEF_HALF=5, active-low LEDs.
module tb_led_div_bank;

  localparam int CH    = 4;
  localparam int CNT_W = 8;
  localparam int CH_W  = 3;

  logic             clk_50M   = 1'b0;
  logic             rst_n     = 1'b1;
  logic             sync      = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch    = '0;
  logic [1:0]       cfg_mode  = '0;
  logic [CNT_W-1:0] cfg_half  = '0;
  logic [CNT_W-1:0] cfg_duty  = '0;
  logic             cfg_err;
  logic [CH-1:0]    led_out;
  logic [CH-1:0]    tick;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        sync;
    logic        valid;
    logic [2:0]  ch;
    logic [1:0]  mode;
    logic [7:0]  half;
    logic [7:0]  duty;
    logic [3:0]  led;
    logic [3:0]  tick;
    logic        ready;
    logic        err;
  } vec_t;

  vec_t vt [16];

  led_div_bank #(
    .CH             (CH),
    .CNT_W          (CNT_W),
    .DEF_HALF       (5),
    .LED_ACTIVE_LOW (1'b1),
    .CH_W           (CH_W)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_duty  (cfg_duty),
    .cfg_err   (cfg_err),
    .led_out   (led_out),
    .tick      (tick)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic idle();
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_half  = '0;
    cfg_duty  = '0;
  endtask

  task automatic drive_cfg(input logic [2:0] ch, input logic [1:0] mode,
                           input logic [7:0] half, input logic [7:0] duty);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_half  = half;
    cfg_duty  = duty;
  endtask

  // Reset asserted between edges must act before the next clock edge.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_led", 0, 32'(led_out), 32'hF);
    chk("rst_tick", 0, 32'(tick), 32'h0);
    chk("rst_ready", 0, 32'(cfg_ready), 32'h0);
    chk("rst_err", 0, 32'(cfg_err), 32'h0);
    repeat (2) @(posedge clk_50M);
    @(negedge clk_50M);
    rst_n = 1'b1;
  endtask

  // Square channel restarted at edge s with period p, observed after edge k.
  function automatic void sq_exp(input int k, input int s, input int p,
                                 output logic t, output logic l);
    t = (k > s) && (((k - s) % p) == 0);
    l = ((((k - s) / p) % 2) == 1);
  endfunction

  task automatic run_default(input int n);
    logic t, l;
    for (int k = 1; k <= n; k++) begin
      step();
      sq_exp(k, 0, 5, t, l);
      chk("def_tick", k, 32'(tick), t ? 32'hF : 32'h0);
      chk("def_led", k, 32'(led_out), l ? 32'h0 : 32'hF);
      chk("def_ready", k, 32'(cfg_ready), 32'h1);
    end
  endtask

  initial begin
    logic       t, l;
    logic [3:0] exp_led, exp_tick;
    int         s, p;

    // Edge-by-edge config corner cases, edges 1..16 after release.
    //            sync valid ch    mode   half   duty   led    tick  rdy  err
    vt[0]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'hF, 4'h0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 3'd2, 2'd1, 8'd0, 8'd0, 4'hF, 4'h0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'hB, 4'h4, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'hF, 4'h4, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'h0, 4'hF, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 3'd2, 2'd2, 8'd4, 8'd9, 4'h0, 4'h0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 3'd2, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'hB, 4'hF, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 3'd2, 2'd2, 8'd4, 8'd0, 4'hF, 4'h0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 3'd5, 2'd3, 8'd1, 8'd1, 4'hF, 4'h0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 3'd5, 2'd3, 8'd1, 8'd1, 4'hF, 4'h0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'hF, 4'h0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'h4, 4'hF, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 4'h4, 4'h0, 1'b1, 1'b0};

    #2;

    // Default 1 Hz-style square on all channels after reset.
    do_reset();
    run_default(16);

    // Reset while tick is high and LEDs lit, then identical restart.
    do_reset();
    run_default(5);
    do_reset();
    run_default(16);

    // Table: ch2 P=1 square, PWM duty>=P, PWM duty=0, ignored and out-of-range requests.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sync = vt[i].sync;
      if (vt[i].valid) drive_cfg(vt[i].ch, vt[i].mode, vt[i].half, vt[i].duty);
      else begin
        cfg_valid = 1'b0;
      end
      step();
      chk("tbl_led", i + 1, 32'(led_out), 32'(vt[i].led));
      chk("tbl_tick", i + 1, 32'(tick), 32'(vt[i].tick));
      chk("tbl_ready", i + 1, 32'(cfg_ready), 32'(vt[i].ready));
      chk("tbl_err", i + 1, 32'(cfg_err), 32'(vt[i].err));
    end
    idle();

    // ch1 PWM period 10 duty 3 applied at edge 2; others keep 5-clock square.
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      idle();
      if (k == 2) drive_cfg(3'd1, 2'd2, 8'd10, 8'd3);
      step();
      for (int b = 0; b < CH; b++) begin
        if (b == 1) begin
          t = (k > 2) && (((k - 2) % 10) == 0);
          l = (k >= 2) && (((k - 2) % 10) < 3);
        end else begin
          sq_exp(k, 0, 5, t, l);
        end
        exp_tick[b] = t;
        exp_led[b]  = ~l;
      end
      chk("pwm_tick", k, 32'(tick), 32'(exp_tick));
      chk("pwm_led", k, 32'(led_out), 32'(exp_led));
      chk("pwm_ready", k, 32'(cfg_ready), (k == 2) ? 32'h0 : 32'h1);
    end
    idle();

    // sync at edge 7, then sync with cfg ch0 half=3 on a wrap edge (17).
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      idle();
      if (k == 7) sync = 1'b1;
      if (k == 17) begin
        sync = 1'b1;
        drive_cfg(3'd0, 2'd1, 8'd3, 8'd0);
      end
      step();
      for (int b = 0; b < CH; b++) begin
        if (k < 7) begin
          s = 0;  p = 5;
        end else if (k < 17) begin
          s = 7;  p = 5;
        end else begin
          s = 17; p = (b == 0) ? 3 : 5;
        end
        sq_exp(k, s, p, t, l);
        exp_tick[b] = t;
        exp_led[b]  = ~l;
      end
      chk("sync_tick", k, 32'(tick), 32'(exp_tick));
      chk("sync_led", k, 32'(led_out), 32'(exp_led));
      chk("sync_ready", k, 32'(cfg_ready), (k == 17) ? 32'h0 : 32'h1);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
